mult_div_unit: RTL and testbench

- Sequential multiply/divide unit for the multicycle MIPS datapath.
- Executes `mult`, `div` and, optionally, `multu`/`divu` on the A/B register operands.
- Holds the results in architectural HI/LO registers, which feed the register-write mux for `mfhi`/`mflo`.
- The controller drives it with a start/busy/done handshake and stalls in a wait state until Done.

---
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential 32-bit multiply/divide unit with HI/LO registers
// for the multicycle MIPS datapath. Radix-2 shift-add multiply and restoring
// divide, 32 iterations each, with a start/busy/done handshake.
// Optional feature macro: MULTDIV_UNSIGNED_EN adds multu (Op=10) and divu (Op=11).
module mult_div_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        WriteHi,
   input  logic        WriteLo,
   input  logic [31:0] WriteData,
   output logic        Busy,
   output logic        Done,
   output logic        DivZero,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

   state_t      state_q;
   logic [4:0]  count_q;
   logic        signA_q, signB_q, isDiv_q, zeroDiv_q;
   logic        busy_q, done_q, divZero_q;
   logic [31:0] mcand_q, divisor_q;
   logic [63:0] product_q;
   logic [31:0] rem_q, quo_q;
   logic [31:0] hi_q, lo_q;

   logic        opValid, isUnsigned;
   logic        signA, signB;
   logic [31:0] magA, magB;
   logic [32:0] prodSum;
   logic [63:0] product_d;
   logic [32:0] remShift;
   logic [33:0] trial;
   logic [31:0] rem_d, quo_d;
   logic        negRes;
   logic [63:0] prodRes;
   logic [31:0] quoRes, remRes;

`ifdef MULTDIV_UNSIGNED_EN
   assign opValid    = 1'b1;
   assign isUnsigned = Op[1];
`else
   assign opValid    = ~Op[1];
   assign isUnsigned = 1'b0;
`endif

   // Operand conditioning at Start plus one iteration step of each algorithm and the final sign fix-up.
   always_comb begin
      signA     = ~isUnsigned & A[31];
      signB     = ~isUnsigned & B[31];
      magA      = signA ? (32'd0 - A) : A;
      magB      = signB ? (32'd0 - B) : B;

      prodSum   = {1'b0, product_q[63:32]} + {1'b0, (product_q[0] ? mcand_q : 32'd0)};
      product_d = {prodSum, product_q[31:1]};

      remShift  = {rem_q, quo_q[31]};
      trial     = {1'b0, remShift} - {2'b00, divisor_q};
      rem_d     = trial[33] ? remShift[31:0] : trial[31:0];
      quo_d     = {quo_q[30:0], ~trial[33]};

      negRes    = signA_q ^ signB_q;
      prodRes   = negRes ? (64'd0 - product_q) : product_q;
      quoRes    = negRes ? (32'd0 - quo_q) : quo_q;
      remRes    = signA_q ? (32'd0 - rem_q) : rem_q;
   end

   // Control FSM, iteration datapath and HI/LO architectural registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         count_q   <= 5'd0;
         signA_q   <= 1'b0;
         signB_q   <= 1'b0;
         isDiv_q   <= 1'b0;
         zeroDiv_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divZero_q <= 1'b0;
         mcand_q   <= 32'd0;
         divisor_q <= 32'd0;
         product_q <= 64'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (WriteHi) hi_q <= WriteData;
               if (WriteLo) lo_q <= WriteData;
               if (Start && opValid) begin
                  signA_q   <= signA;
                  signB_q   <= signB;
                  isDiv_q   <= Op[0];
                  count_q   <= 5'd0;
                  divZero_q <= 1'b0;
                  busy_q    <= 1'b1;
                  if (Op[0]) begin
                     zeroDiv_q <= (B == 32'd0);
                     rem_q     <= 32'd0;
                     quo_q     <= magA;
                     divisor_q <= magB;
                     state_q   <= DIV;
                  end else begin
                     zeroDiv_q <= 1'b0;
                     mcand_q   <= magA;
                     product_q <= {32'd0, magB};
                     state_q   <= MULT;
                  end
               end
            end
            MULT: begin
               product_q <= product_d;
               count_q   <= count_q + 5'd1;
               if (count_q == 5'd31) state_q <= FINISH;
            end
            DIV: begin
               if (zeroDiv_q) begin
                  state_q <= FINISH;
               end else begin
                  rem_q   <= rem_d;
                  quo_q   <= quo_d;
                  count_q <= count_q + 5'd1;
                  if (count_q == 5'd31) state_q <= FINISH;
               end
            end
            FINISH: begin
               if (zeroDiv_q) begin
                  divZero_q <= 1'b1;
               end else if (isDiv_q) begin
                  lo_q <= quoRes;
                  hi_q <= remRes;
               end else begin
                  hi_q <= prodRes[63:32];
                  lo_q <= prodRes[31:0];
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DivZero = divZero_q;
   assign Hi      = hi_q;
   assign Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit. Stimulus pushes the
// hand-computed HI/LO/DivZero result and the expected Done cycle; a monitor
// pops and compares whenever Done is seen. Honours MULTDIV_UNSIGNED_EN.
module tb_mult_div_unit;

   logic        Clk, Reset, Start, WriteHi, WriteLo;
   logic [1:0]  Op;
   logic [31:0] A, B, WriteData;
   logic        Busy, Done, DivZero;
   logic [31:0] Hi, Lo;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          doneCycle;
   } exp_t;

   exp_t sb[$];
   int   cycle = 0;
   int   testsRun = 0;
   int   testsFailed = 0;

   mult_div_unit dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
      .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
   );

   // 10-time-unit clock; inputs change and outputs are sampled on the falling edge.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Rising-edge counter used to measure Start-to-Done latency.
   always @(posedge Clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Monitor: every Done pulse must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      if (Reset === 1'b1 && Done === 1'b1) begin
         if (sb.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected Done: got Hi=%h Lo=%h with no operation outstanding", Hi, Lo);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.name, " Hi"}, Hi, e.hi);
            checkOutput({e.name, " Lo"}, Lo, e.lo);
            checkOutput({e.name, " DivZero"}, {31'd0, DivZero}, {31'd0, e.dz});
            checkOutput({e.name, " Done cycle"}, cycle, e.doneCycle);
            checkOutput({e.name, " Busy at Done"}, {31'd0, Busy}, 32'd0);
         end
      end
   end

   // Issues one Start (called on a falling edge) and records the expected result.
   task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                                input logic expDz, input int latency);
      exp_t e;
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      e.name      = name;
      e.hi        = expHi;
      e.lo        = expLo;
      e.dz        = expDz;
      e.doneCycle = cycle + 1 + latency;
      sb.push_back(e);
      @(negedge Clk);
      Start   = 1'b0;
      WriteHi = 1'b0;
      WriteLo = 1'b0;
      A       = 32'hDEAD_BEEF;
      B       = 32'h0BAD_F00D;
   endtask

   // Waits on falling edges until Done, bounded by a cycle budget.
   task automatic waitDone(input string name, input int budget);
      int n = 0;
      while (Done !== 1'b1 && n < budget) begin
         @(negedge Clk);
         n++;
      end
      if (Done !== 1'b1) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s timeout: got no Done within %0d cycles, required Done", name, budget);
         sb.delete();
      end
   endtask

   initial begin
      Reset = 1'b0; Start = 1'b0; Op = 2'b00; A = 32'd0; B = 32'd0;
      WriteHi = 1'b0; WriteLo = 1'b0; WriteData = 32'd0;

      @(negedge Clk);
      checkOutput("reset Hi", Hi, 32'd0);
      checkOutput("reset Lo", Lo, 32'd0);
      checkOutput("reset Busy", {31'd0, Busy}, 32'd0);
      checkOutput("reset Done", {31'd0, Done}, 32'd0);
      checkOutput("reset DivZero", {31'd0, DivZero}, 32'd0);
      Reset = 1'b1;
      @(negedge Clk);

      applyStimulus("mult 7*-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
      checkOutput("Busy after Start", {31'd0, Busy}, 32'd1);
      waitDone("mult 7*-3", 40);

      applyStimulus("div -7/2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
      waitDone("div -7/2", 40);

      applyStimulus("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33);
      waitDone("mult min*min", 40);

      applyStimulus("div min/-1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
      waitDone("div min/-1", 40);
      @(negedge Clk);

      WriteLo = 1'b1; WriteData = 32'h5555;
      @(negedge Clk);
      WriteLo = 1'b0;
      checkOutput("mtlo", Lo, 32'h5555);

      WriteHi = 1'b1; WriteData = 32'h1234;
      applyStimulus("div 5/0 with mthi", 2'b01, 32'd5, 32'd0, 32'h1234, 32'h5555, 1'b1, 2);
      waitDone("div 5/0", 10);
      @(negedge Clk);
      checkOutput("DivZero held", {31'd0, DivZero}, 32'd1);
      checkOutput("Done one cycle", {31'd0, Done}, 32'd0);

      applyStimulus("mult 3*4 ignore Start/mtlo", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33);
      repeat (9) @(negedge Clk);
      Start = 1'b1; Op = 2'b01; A = 32'd100; B = 32'd7; WriteLo = 1'b1; WriteData = 32'hAAAA;
      @(negedge Clk);
      Start = 1'b0; WriteLo = 1'b0;
      checkOutput("mtlo while Busy", Lo, 32'h5555);
      waitDone("mult 3*4", 40);
      @(negedge Clk);

      Start = 1'b1; Op = 2'b00; A = 32'd9; B = 32'd9;
      @(negedge Clk);
      Start = 1'b0;
      repeat (14) @(negedge Clk);
      Reset = 1'b0;
      #1;
      checkOutput("abort Busy", {31'd0, Busy}, 32'd0);
      checkOutput("abort Done", {31'd0, Done}, 32'd0);
      checkOutput("abort Hi", Hi, 32'd0);
      checkOutput("abort Lo", Lo, 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);

      applyStimulus("div 100/7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
      waitDone("div 100/7", 40);
      @(negedge Clk);

`ifdef MULTDIV_UNSIGNED_EN
      applyStimulus("multu", 2'b10, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 33);
      waitDone("multu", 40);
      @(negedge Clk);
      applyStimulus("divu", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b0, 33);
      waitDone("divu", 40);
`else
      Start = 1'b1; Op = 2'b10; A = 32'hFFFF_FFFF; B = 32'd2;
      @(negedge Clk);
      Start = 1'b0;
      checkOutput("multu disabled Busy", {31'd0, Busy}, 32'd0);
      repeat (36) @(negedge Clk);
      checkOutput("multu disabled Hi", Hi, 32'd2);
      checkOutput("multu disabled Lo", Lo, 32'd14);
`endif

      repeat (40) @(negedge Clk);
      checkOutput("scoreboard drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
